// File: rtl/npc_sim_monitor.sv
// End-of-simulation monitor for the NPC core: detects ebreak, commit stalls and
// cycle limits, latches the halt context, then raises done after a drain delay.
module npc_sim_monitor #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     NRET       = 1,
  parameter int unsigned     TIMEOUT    = 4096,
  parameter longint unsigned MAX_CYCLES = 0,
  parameter int unsigned     DRAIN      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NRET-1:0]        commit_valid,
  input  logic [32*NRET-1:0]     commit_inst,
  input  logic [XLEN*NRET-1:0]   commit_pc,
  input  logic [XLEN-1:0]        a0_value,
  output logic                   halted,
  output logic                   done,
  output logic [2:0]             halt_reason,
  output logic [XLEN-1:0]        exit_code,
  output logic [XLEN-1:0]        halt_pc,
  output logic [63:0]            cycle_cnt,
  output logic [63:0]            inst_cnt
);

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [63:0] MAX_W     = 64'(MAX_CYCLES);
  localparam logic [31:0] DRAIN_W   = 32'(DRAIN);

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_GOOD  = 3'd1;
  localparam logic [2:0] R_BAD   = 3'd2;
  localparam logic [2:0] R_TIMEO = 3'd3;
  localparam logic [2:0] R_LIMIT = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      reason_q, reason_d;
  logic [XLEN-1:0] exit_q, exit_d;
  logic [XLEN-1:0] hpc_q, hpc_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [63:0]     cycle_q, cycle_d;
  logic [63:0]     inst_q, inst_d;
  logic [31:0]     idle_q, idle_d;
  logic [31:0]     drain_q, drain_d;

  logic            ebreak_hit;
  logic            any_commit;
  logic [XLEN-1:0] ebreak_pc;
  logic [XLEN-1:0] top_pc;
  logic [63:0]     lane_cnt;

  // Walk lanes in retirement order; lanes younger than the first ebreak do not count.
  always_comb begin
    ebreak_hit = 1'b0;
    ebreak_pc  = '0;
    top_pc     = last_pc_q;
    lane_cnt   = '0;
    any_commit = |commit_valid;
    for (int i = 0; i < int'(NRET); i++) begin
      if (commit_valid[i] && !ebreak_hit) begin
        lane_cnt = lane_cnt + 64'd1;
        top_pc   = commit_pc[i*XLEN +: XLEN];
        if (commit_inst[i*32 +: 32] == EBREAK) begin
          ebreak_hit = 1'b1;
          ebreak_pc  = commit_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    reason_d  = reason_q;
    exit_d    = exit_q;
    hpc_d     = hpc_q;
    last_pc_d = last_pc_q;
    cycle_d   = cycle_q;
    inst_d    = inst_q;
    idle_d    = idle_q;
    drain_d   = drain_q;
    unique case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + 64'd1;
        inst_d  = inst_q + lane_cnt;
        if (any_commit) begin
          last_pc_d = top_pc;
          idle_d    = '0;
        end else if (idle_q != TIMEOUT_W) begin
          idle_d = idle_q + 32'd1;
        end
        if (ebreak_hit) begin
          reason_d = (a0_value == '0) ? R_GOOD : R_BAD;
          exit_d   = a0_value;
          hpc_d    = ebreak_pc;
          state_d  = ST_DRAIN;
        end else if ((MAX_W != 64'd0) && (cycle_q + 64'd1 == MAX_W)) begin
          reason_d = R_LIMIT;
          exit_d   = '1;
          hpc_d    = last_pc_d;
          state_d  = ST_DRAIN;
        end else if ((TIMEOUT_W != 32'd0) && !any_commit &&
                     (idle_q == TIMEOUT_W - 32'd1)) begin
          reason_d = R_TIMEO;
          exit_d   = '1;
          hpc_d    = last_pc_d;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // DRAIN of 0 or 1 both leave after a single drain cycle.
        if (drain_q + 32'd1 >= DRAIN_W) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      reason_q  <= R_NONE;
      exit_q    <= '0;
      hpc_q     <= '0;
      last_pc_q <= '0;
      cycle_q   <= '0;
      inst_q    <= '0;
      idle_q    <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      reason_q  <= reason_d;
      exit_q    <= exit_d;
      hpc_q     <= hpc_d;
      last_pc_q <= last_pc_d;
      cycle_q   <= cycle_d;
      inst_q    <= inst_d;
      idle_q    <= idle_d;
      drain_q   <= drain_d;
    end
  end

  assign halted      = (state_q != ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign halt_reason = reason_q;
  assign exit_code   = exit_q;
  assign halt_pc     = hpc_q;
  assign cycle_cnt   = cycle_q;
  assign inst_cnt    = inst_q;

endmodule
